cpu_controller: RTL and testbench

//  Multicycle control FSM for the 16-bit CR16-style CPU. It fetches and decodes instructions and drives the
//  ALU's alucode, operand muxes and status input. It owns the PSR, which latches the ALU flags output.

---
 rtl/cpu_defs_pkg.sv | 80 ++++++++
 rtl/cond_eval.sv | 31 +++
 rtl/cpu_controller.sv | 201 ++++++++++++++++++++
 tb/tb_cpu_controller.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: ALU codes, opcode/ext encodings, condition codes,
// PSR bit indices, writeback selects and controller state encoding.
// CPU_TRAP_ILLEGAL_EN adds the terminal HALT state.
package cpu_defs_pkg;
  localparam int CPU_WIDTH  = 16;
  localparam int CPU_FLAG_W = 5;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_CMP   = 4'b0010;
  localparam logic [3:0] ALU_AND   = 4'b0011;
  localparam logic [3:0] ALU_OR    = 4'b0100;
  localparam logic [3:0] ALU_XOR   = 4'b0101;
  localparam logic [3:0] ALU_LSH   = 4'b0110;
  localparam logic [3:0] ALU_LUI   = 4'b0111;
  localparam logic [3:0] ALU_JCOND = 4'b1000;
  localparam logic [3:0] ALU_BCOND = 4'b1001;
  localparam logic [3:0] ALU_PASS  = 4'b1111;

  // Major opcodes IR[15:12]; 6, 7, A and F are undefined
  localparam logic [3:0] OP_REG   = 4'h0;
  localparam logic [3:0] OP_ANDI  = 4'h1;
  localparam logic [3:0] OP_ORI   = 4'h2;
  localparam logic [3:0] OP_XORI  = 4'h3;
  localparam logic [3:0] OP_MISC  = 4'h4;
  localparam logic [3:0] OP_ADDI  = 4'h5;
  localparam logic [3:0] OP_SHIFT = 4'h8;
  localparam logic [3:0] OP_SUBI  = 4'h9;
  localparam logic [3:0] OP_CMPI  = 4'hB;
  localparam logic [3:0] OP_BCOND = 4'hC;
  localparam logic [3:0] OP_MOVI  = 4'hD;
  localparam logic [3:0] OP_LUI   = 4'hE;

  // Extended opcodes IR[7:4]
  localparam logic [3:0] EXT_AND   = 4'h1;
  localparam logic [3:0] EXT_OR    = 4'h2;
  localparam logic [3:0] EXT_XOR   = 4'h3;
  localparam logic [3:0] EXT_ADD   = 4'h5;
  localparam logic [3:0] EXT_SUB   = 4'h9;
  localparam logic [3:0] EXT_CMP   = 4'hB;
  localparam logic [3:0] EXT_MOV   = 4'hD;
  localparam logic [3:0] EXT_LSH   = 4'h4;  // under OP_SHIFT; LSHI is ext 000s
  localparam logic [3:0] EXT_LOAD  = 4'h0;  // under OP_MISC
  localparam logic [3:0] EXT_STOR  = 4'h4;
  localparam logic [3:0] EXT_JAL   = 4'h8;
  localparam logic [3:0] EXT_JCOND = 4'hC;

  // Condition codes
  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
  localparam logic [3:0] COND_HI = 4'h4, COND_LS = 4'h5, COND_GT = 4'h6, COND_LE = 4'h7;
  localparam logic [3:0] COND_FS = 4'h8, COND_FC = 4'h9, COND_LO = 4'hA, COND_HS = 4'hB;
  localparam logic [3:0] COND_LT = 4'hC, COND_GE = 4'hD, COND_UC = 4'hE, COND_NV = 4'hF;

  // PSR bit indices
  localparam int PSR_C = 4;
  localparam int PSR_L = 3;
  localparam int PSR_F = 2;
  localparam int PSR_Z = 1;
  localparam int PSR_N = 0;

  // Register-file writeback sources
  localparam logic [1:0] WSEL_ALU  = 2'd0;
  localparam logic [1:0] WSEL_MEM  = 2'd1;
  localparam logic [1:0] WSEL_LINK = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM
`ifdef CPU_TRAP_ILLEGAL_EN
    , S_HALT
`endif
  } state_e;

  // Instruction classes produced by decode
  typedef enum logic [2:0] {
    K_ILL, K_ALU, K_CMP, K_JCOND, K_BCOND, K_JAL, K_LOAD, K_STOR
  } kind_e;

  typedef enum logic [1:0] {IMM_SEXT, IMM_ZEXT, IMM_SH5} imm_mode_e;
endpackage

// File: rtl/cond_eval.sv
// Condition evaluator: maps PSR and a 4-bit condition field to branch-taken.
module cond_eval
  import cpu_defs_pkg::*;
(
  input  logic [CPU_FLAG_W-1:0] psr,
  input  logic [3:0]            cond,
  output logic                  status
);
  // Table of condition codes over the PSR flags
  always_comb begin
    status = 1'b0;
    case (cond)
      COND_EQ: status = psr[PSR_Z];
      COND_NE: status = !psr[PSR_Z];
      COND_CS: status = psr[PSR_C];
      COND_CC: status = !psr[PSR_C];
      COND_HI: status = psr[PSR_L];
      COND_LS: status = !psr[PSR_L];
      COND_GT: status = psr[PSR_N];
      COND_LE: status = !psr[PSR_N];
      COND_FS: status = psr[PSR_F];
      COND_FC: status = !psr[PSR_F];
      COND_LO: status = !psr[PSR_L] && !psr[PSR_Z];
      COND_HS: status = psr[PSR_L] || psr[PSR_Z];
      COND_LT: status = !psr[PSR_N] && !psr[PSR_Z];
      COND_GE: status = psr[PSR_N] || psr[PSR_Z];
      COND_UC: status = 1'b1;
      default: status = 1'b0;
    endcase
  end
endmodule

// File: rtl/cpu_controller.sv
// Multicycle control FSM for the CR16-style CPU: fetch, decode, execute and
// memory phases, IR and PSR ownership. With CPU_TRAP_ILLEGAL_EN defined an
// undefined encoding halts the core; otherwise it executes as a NOP.
module cpu_controller
  import cpu_defs_pkg::*;
#(
  parameter int WIDTH  = CPU_WIDTH,
  parameter int FLAG_W = CPU_FLAG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_ready,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic [3:0]        alucode,
  output logic              status,
  output logic [1:0]        a_sel,
  output logic              b_sel,
  output logic [WIDTH-1:0]  imm,
  output logic [3:0]        rsrc,
  output logic [3:0]        rdest,
  output logic              rf_we,
  output logic [1:0]        rf_wsel,
  output logic              pc_we,
  output logic              pc_src,
  output logic              addr_src,
  output logic              mem_req,
  output logic              mem_we,
  output logic [FLAG_W-1:0] psr,
  output logic              illegal
);
  state_e            state_q, state_d;
  logic [WIDTH-1:0]  ir_q, ir_d;
  logic [FLAG_W-1:0] psr_q, psr_d;

  kind_e       kind;
  imm_mode_e   imm_mode;
  logic [3:0]  dec_alu;
  logic        dec_asel;
  logic        cond_true;
  logic        alu_on;
  logic [WIDTH-1:0] imm_val;
  logic        rf_we_c, pc_we_c, mem_we_c, illegal_c;

  logic [3:0] op, ext;
  assign op  = ir_q[15:12];
  assign ext = ir_q[7:4];

  cond_eval u_cond (.psr(psr_q), .cond(ir_q[11:8]), .status(cond_true));

  // Instruction decode from the registered IR
  always_comb begin
    kind     = K_ILL;
    dec_alu  = ALU_PASS;
    dec_asel = 1'b0;
    imm_mode = IMM_SEXT;
    case (op)
      OP_REG: begin
        case (ext)
          EXT_ADD: begin kind = K_ALU; dec_alu = ALU_ADD; end
          EXT_SUB: begin kind = K_ALU; dec_alu = ALU_SUB; end
          EXT_CMP: begin kind = K_CMP; dec_alu = ALU_CMP; end
          EXT_AND: begin kind = K_ALU; dec_alu = ALU_AND; end
          EXT_OR:  begin kind = K_ALU; dec_alu = ALU_OR;  end
          EXT_XOR: begin kind = K_ALU; dec_alu = ALU_XOR; end
          EXT_MOV: begin kind = K_ALU; dec_alu = ALU_PASS; end
          default: ;
        endcase
      end
      OP_ADDI: begin kind = K_ALU; dec_alu = ALU_ADD; dec_asel = 1'b1; end
      OP_SUBI: begin kind = K_ALU; dec_alu = ALU_SUB; dec_asel = 1'b1; end
      OP_CMPI: begin kind = K_CMP; dec_alu = ALU_CMP; dec_asel = 1'b1; end
      OP_MOVI: begin kind = K_ALU; dec_alu = ALU_PASS; dec_asel = 1'b1; end
      OP_ANDI: begin kind = K_ALU; dec_alu = ALU_AND; dec_asel = 1'b1; imm_mode = IMM_ZEXT; end
      OP_ORI:  begin kind = K_ALU; dec_alu = ALU_OR;  dec_asel = 1'b1; imm_mode = IMM_ZEXT; end
      OP_XORI: begin kind = K_ALU; dec_alu = ALU_XOR; dec_asel = 1'b1; imm_mode = IMM_ZEXT; end
      OP_LUI:  begin kind = K_ALU; dec_alu = ALU_LUI; dec_asel = 1'b1; imm_mode = IMM_ZEXT; end
      OP_SHIFT: begin
        if (ext == EXT_LSH) begin
          kind = K_ALU; dec_alu = ALU_LSH;
        end else if (ext[3:1] == 3'b000) begin
          kind = K_ALU; dec_alu = ALU_LSH; dec_asel = 1'b1; imm_mode = IMM_SH5;
        end
      end
      OP_MISC: begin
        case (ext)
          EXT_LOAD:  kind = K_LOAD;
          EXT_STOR:  kind = K_STOR;
          EXT_JCOND: begin kind = K_JCOND; dec_alu = ALU_JCOND; end
          EXT_JAL:   begin kind = K_JAL;   dec_alu = ALU_JCOND; end
          default: ;
        endcase
      end
      OP_BCOND: begin kind = K_BCOND; dec_alu = ALU_BCOND; dec_asel = 1'b1; end
      default: ;
    endcase
  end

  // Immediate formatting: logic ops zero-extend, LSHI takes a 5-bit signed count
  always_comb begin
    imm_val = {{(WIDTH-8){ir_q[7]}}, ir_q[7:0]};
    if (imm_mode == IMM_ZEXT)     imm_val = {{(WIDTH-8){1'b0}}, ir_q[7:0]};
    else if (imm_mode == IMM_SH5) imm_val = {{(WIDTH-5){ir_q[4]}}, ir_q[4:0]};
  end

  // ALU-facing controls are only meaningful while an instruction is being decoded/executed
  assign alu_on  = (state_q == S_DECODE) || (state_q == S_EXEC);
  assign alucode = alu_on ? dec_alu : 4'b0000;
  assign a_sel   = alu_on ? {1'b0, dec_asel} : 2'b00;
  assign b_sel   = alu_on && (kind == K_JCOND || kind == K_BCOND || kind == K_JAL);
  assign imm     = alu_on ? imm_val : '0;
  assign status  = alu_on && ((kind == K_JAL) ||
                   ((kind == K_JCOND || kind == K_BCOND) && cond_true));
  assign rsrc    = ir_q[3:0];
  assign rdest   = ir_q[11:8];
  assign psr     = psr_q;

  // Strobes fall with reset immediately so no partial writeback can occur
  assign rf_we  = rf_we_c  && !reset;
  assign pc_we  = pc_we_c  && !reset;
  assign mem_we = mem_we_c && !reset;
`ifdef CPU_TRAP_ILLEGAL_EN
  assign illegal = illegal_c;
`else
  assign illegal = 1'b0;
`endif

  // Next-state and per-state strobe generation
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    psr_d     = psr_q;
    mem_req   = 1'b0;
    addr_src  = 1'b0;
    rf_we_c   = 1'b0;
    rf_wsel   = WSEL_ALU;
    pc_we_c   = 1'b0;
    pc_src    = 1'b0;
    mem_we_c  = 1'b0;
    illegal_c = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
`ifdef CPU_TRAP_ILLEGAL_EN
        if (kind == K_ILL) begin
          illegal_c = 1'b1;
          state_d   = S_HALT;
        end
`endif
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (kind)
          K_ALU: begin rf_we_c = 1'b1; pc_we_c = 1'b1; end
          K_CMP: begin pc_we_c = 1'b1; psr_d = alu_flags; end
          K_JCOND, K_BCOND: begin pc_we_c = 1'b1; pc_src = 1'b1; end
          K_JAL: begin
            rf_we_c = 1'b1; rf_wsel = WSEL_LINK; pc_we_c = 1'b1; pc_src = 1'b1;
          end
          K_LOAD, K_STOR: state_d = S_MEM;
          default: pc_we_c = 1'b1;  // undefined encoding runs as NOP
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_src = 1'b1;
        if (mem_ready) begin
          mem_we_c = (kind == K_STOR);
          rf_we_c  = (kind == K_LOAD);
          rf_wsel  = (kind == K_LOAD) ? WSEL_MEM : WSEL_ALU;
          pc_we_c  = 1'b1;
          state_d  = S_FETCH;
        end
      end
`ifdef CPU_TRAP_ILLEGAL_EN
      S_HALT: illegal_c = 1'b1;
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // State, IR and PSR registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      psr_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      psr_q   <= psr_d;
    end
  end
endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: directed scenarios then random
// instruction streams against an instruction-level reference model.
module tb_cpu_controller;
  logic        clk, reset;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic [4:0]  alu_flags;
  logic [3:0]  alucode;
  logic        status;
  logic [1:0]  a_sel;
  logic        b_sel;
  logic [15:0] imm;
  logic [3:0]  rsrc, rdest;
  logic        rf_we;
  logic [1:0]  rf_wsel;
  logic        pc_we, pc_src, addr_src, mem_req, mem_we;
  logic [4:0]  psr;
  logic        illegal;

  int vectors = 0;
  int miscompares = 0;
  logic [4:0] mpsr;   // model PSR

  cpu_controller dut (
    .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .alu_flags(alu_flags), .alucode(alucode), .status(status), .a_sel(a_sel),
    .b_sel(b_sel), .imm(imm), .rsrc(rsrc), .rdest(rdest), .rf_we(rf_we),
    .rf_wsel(rf_wsel), .pc_we(pc_we), .pc_src(pc_src), .addr_src(addr_src),
    .mem_req(mem_req), .mem_we(mem_we), .psr(psr), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {C_ALU, C_CMP, C_JC, C_BC, C_JAL, C_LD, C_ST, C_ILL} cls_e;
  typedef struct {
    logic [3:0] op;
    logic [3:0] ext;
    bit         reg_form;
    cls_e       cls;
    logic [3:0] alu;
    bit         asel;
    int         immk;   // 0 sign-ext imm8, 1 zero-ext imm8, 2 sign-ext imm[4:0]
  } tpl_t;
  tpl_t tpls[$];

  function automatic tpl_t mk(logic [3:0] op, logic [3:0] ext, bit rf, cls_e c,
                              logic [3:0] alu, bit asel, int immk);
    tpl_t t;
    t.op = op; t.ext = ext; t.reg_form = rf; t.cls = c;
    t.alu = alu; t.asel = asel; t.immk = immk;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Condition-code truth table over the PSR flags {C,L,F,Z,N}
  function automatic bit cond_true(logic [4:0] p, logic [3:0] c);
    bit fc, fl, ff, fz, fn;
    fc = p[4]; fl = p[3]; ff = p[2]; fz = p[1]; fn = p[0];
    case (c)
      4'h0: return fz;        4'h1: return !fz;
      4'h2: return fc;        4'h3: return !fc;
      4'h4: return fl;        4'h5: return !fl;
      4'h6: return fn;        4'h7: return !fn;
      4'h8: return ff;        4'h9: return !ff;
      4'hA: return !fl && !fz; 4'hB: return fl || fz;
      4'hC: return !fn && !fz; 4'hD: return fn || fz;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] exp_imm(logic [15:0] i, int immk);
    if (immk == 1) return {8'h00, i[7:0]};
    if (immk == 2) return {{11{i[4]}}, i[4:0]};
    return {{8{i[7]}}, i[7:0]};
  endfunction

  function automatic logic [15:0] build(tpl_t t);
    logic [3:0] rd, rs, ext;
    logic [7:0] imm8;
    rd = 4'($urandom); rs = 4'($urandom); imm8 = 8'($urandom);
    ext = t.ext;
    if (t.immk == 2) ext = {3'b000, 1'($urandom)};
    return t.reg_form ? {t.op, rd, ext, rs} : {t.op, rd, imm8};
  endfunction

  // One instruction, cycle by cycle: fw fetch wait states, mw memory wait states.
  // Inputs change just after the falling edge, outputs are sampled 1 time unit later.
  task automatic run_instr(input logic [15:0] instr, input tpl_t t, input int fw,
                           input int mw, input int fl_force);
    logic [4:0] fl;
    bit mem_op, br, wr, exp_st;
    mem_op = (t.cls == C_LD) || (t.cls == C_ST);
    br     = (t.cls == C_JC) || (t.cls == C_BC) || (t.cls == C_JAL);
    wr     = (t.cls == C_ALU) || (t.cls == C_JAL);
    for (int k = 0; k <= fw; k++) begin
      mem_ready = (k == fw);
      mem_rdata = (k == fw) ? instr : 16'($urandom);
      alu_flags = 5'($urandom);
      #1;
      chk("fetch_req", 16'(mem_req), 16'd1);
      chk("fetch_addr", 16'(addr_src), 16'd0);
      chk("fetch_strobes", 16'({rf_we, pc_we, mem_we}), 16'd0);
      @(negedge clk);
    end
    mem_ready = 1'b0; mem_rdata = 16'($urandom);
    exp_st = (t.cls == C_JAL) ? 1'b1 : cond_true(mpsr, instr[11:8]);
    #1;
    chk("dec_strobes", 16'({rf_we, pc_we, mem_we, mem_req}), 16'd0);
`ifdef CPU_TRAP_ILLEGAL_EN
    if (t.cls == C_ILL) begin
      chk("dec_illegal", 16'(illegal), 16'd1);
      @(negedge clk);
      for (int k = 0; k < 20; k++) begin
        mem_ready = 1'($urandom); mem_rdata = 16'($urandom);
        #1;
        chk("halt_quiet", 16'({rf_we, pc_we, mem_we, mem_req}), 16'd0);
        @(negedge clk);
      end
      reset = 1'b1; mem_ready = 1'b0;
      @(negedge clk);
      reset = 1'b0; mpsr = '0;
      return;
    end
`else
    chk("dec_illegal", 16'(illegal), 16'd0);
`endif
    if (br) chk("dec_status", 16'(status), 16'(exp_st));
    @(negedge clk);
    // EXEC
    fl = (fl_force < 0) ? 5'($urandom) : 5'(fl_force);
    alu_flags = fl; mem_ready = 1'($urandom);
    #1;
    chk("ex_rf_we", 16'(rf_we), 16'(wr));
    chk("ex_pc_we", 16'(pc_we), 16'(!mem_op));
    chk("ex_pc_src", 16'(pc_src), 16'(br));
    chk("ex_mem", 16'({mem_req, mem_we}), 16'd0);
    chk("ex_rdest", 16'(rdest), 16'(instr[11:8]));
    chk("ex_rsrc", 16'(rsrc), 16'(instr[3:0]));
    if (wr) chk("ex_rf_wsel", 16'(rf_wsel), (t.cls == C_JAL) ? 16'd2 : 16'd0);
    if (t.cls != C_ILL && t.cls != C_JAL && !mem_op) begin
      chk("ex_alucode", 16'(alucode), 16'(t.alu));
      chk("ex_a_sel", 16'(a_sel), 16'(t.asel));
    end
    if (t.asel) chk("ex_imm", imm, exp_imm(instr, t.immk));
    if (br) begin
      chk("ex_b_sel", 16'(b_sel), 16'd1);
      chk("ex_status", 16'(status), 16'(exp_st));
    end
    @(negedge clk);
    if (t.cls == C_CMP) mpsr = fl;
    if (mem_op) begin
      for (int k = 0; k <= mw; k++) begin
        mem_ready = (k == mw); mem_rdata = 16'($urandom); alu_flags = 5'($urandom);
        #1;
        chk("mem_req", 16'({mem_req, addr_src}), 16'b11);
        chk("mem_rf_we", 16'(rf_we), 16'((t.cls == C_LD) && (k == mw)));
        chk("mem_rf_wsel", 16'(rf_wsel), ((t.cls == C_LD) && (k == mw)) ? 16'd1 : 16'd0);
        chk("mem_we", 16'(mem_we), 16'((t.cls == C_ST) && (k == mw)));
        chk("mem_pc", 16'({pc_we, pc_src}), (k == mw) ? 16'b10 : 16'b00);
        @(negedge clk);
      end
    end
    mem_ready = 1'b0;
    #1;
    chk("psr", 16'(psr), 16'(mpsr));
  endtask

  initial begin
    tpl_t t;
    logic [15:0] ins;
    tpls.push_back(mk(4'h0, 4'h5, 1, C_ALU, 4'b0000, 0, 0));  // ADD
    tpls.push_back(mk(4'h0, 4'h9, 1, C_ALU, 4'b0001, 0, 0));  // SUB
    tpls.push_back(mk(4'h0, 4'hB, 1, C_CMP, 4'b0010, 0, 0));  // CMP
    tpls.push_back(mk(4'h0, 4'h1, 1, C_ALU, 4'b0011, 0, 0));  // AND
    tpls.push_back(mk(4'h0, 4'h2, 1, C_ALU, 4'b0100, 0, 0));  // OR
    tpls.push_back(mk(4'h0, 4'h3, 1, C_ALU, 4'b0101, 0, 0));  // XOR
    tpls.push_back(mk(4'h0, 4'hD, 1, C_ALU, 4'b1111, 0, 0));  // MOV
    tpls.push_back(mk(4'h8, 4'h4, 1, C_ALU, 4'b0110, 0, 0));  // LSH
    tpls.push_back(mk(4'h8, 4'h0, 1, C_ALU, 4'b0110, 1, 2));  // LSHI
    tpls.push_back(mk(4'h5, 4'h0, 0, C_ALU, 4'b0000, 1, 0));  // ADDI
    tpls.push_back(mk(4'h9, 4'h0, 0, C_ALU, 4'b0001, 1, 0));  // SUBI
    tpls.push_back(mk(4'hB, 4'h0, 0, C_CMP, 4'b0010, 1, 0));  // CMPI
    tpls.push_back(mk(4'h1, 4'h0, 0, C_ALU, 4'b0011, 1, 1));  // ANDI
    tpls.push_back(mk(4'h2, 4'h0, 0, C_ALU, 4'b0100, 1, 1));  // ORI
    tpls.push_back(mk(4'h3, 4'h0, 0, C_ALU, 4'b0101, 1, 1));  // XORI
    tpls.push_back(mk(4'hD, 4'h0, 0, C_ALU, 4'b1111, 1, 0));  // MOVI
    tpls.push_back(mk(4'hE, 4'h0, 0, C_ALU, 4'b0111, 1, 1));  // LUI
    tpls.push_back(mk(4'h4, 4'h0, 1, C_LD,  4'b0000, 0, 0));  // LOAD
    tpls.push_back(mk(4'h4, 4'h4, 1, C_ST,  4'b0000, 0, 0));  // STOR
    tpls.push_back(mk(4'h4, 4'hC, 1, C_JC,  4'b1000, 0, 0));  // Jcond
    tpls.push_back(mk(4'h4, 4'h8, 1, C_JAL, 4'b1000, 0, 0));  // JAL
    tpls.push_back(mk(4'hC, 4'h0, 0, C_BC,  4'b1001, 1, 0));  // Bcond
    tpls.push_back(mk(4'h6, 4'h0, 0, C_ILL, 4'b0000, 0, 0));
    tpls.push_back(mk(4'h7, 4'h0, 0, C_ILL, 4'b0000, 0, 0));
    tpls.push_back(mk(4'hA, 4'h0, 0, C_ILL, 4'b0000, 0, 0));
    tpls.push_back(mk(4'hF, 4'h0, 0, C_ILL, 4'b0000, 0, 0));

    // Reset state
    reset = 1'b1; mem_ready = 1'b0; mem_rdata = 16'h0; alu_flags = 5'h0; mpsr = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_req", 16'(mem_req), 16'd1);
    chk("rst_strobes", 16'({rf_we, pc_we, mem_we, pc_src, addr_src, rf_wsel}), 16'd0);
    chk("rst_alu", 16'({alucode, status, a_sel, b_sel, illegal}), 16'd0);
    chk("rst_psr", 16'(psr), 16'd0);
    chk("rst_imm", imm, 16'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed: ADD R1,R2
    run_instr(16'h0152, tpls[0], 0, 0, -1);
    // CMPI 5,R3 sets Z, then BEQ +4 is taken
    run_instr(16'hB305, tpls[11], 0, 0, 5'b00010);
    run_instr(16'hC004, tpls[21], 0, 0, -1);
    // LOAD with three memory wait states
    run_instr(16'h4203, tpls[17], 0, 3, -1);
    // JAL R14,R5
    run_instr(16'h4E85, tpls[20], 0, 0, -1);
    // Jcond NV never taken, self-branch UC taken
    run_instr(16'h4FC7, tpls[19], 0, 0, -1);
    run_instr(16'hCE00, tpls[21], 1, 0, -1);

    // Reset in the middle of an ADD's EXEC cycle after PSR was made nonzero
    run_instr(16'hB300, tpls[11], 0, 0, 5'b10101);
    mem_ready = 1'b1; mem_rdata = 16'h0152;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rf_we_pre", 16'({rf_we, pc_we}), 16'b11);
    reset = 1'b1;
    #1;
    chk("mid_strobes_drop", 16'({rf_we, pc_we}), 16'b00);
    chk("mid_psr", 16'(psr), 16'd0);
    @(negedge clk);
    reset = 1'b0; mpsr = '0;
    #1;
    chk("mid_fetch", 16'({mem_req, rf_we, pc_we}), 16'b100);

    // Undefined opcode 0xF000: halt or NOP depending on build
    run_instr(16'hF000, tpls[25], 0, 0, -1);

    // Random instruction stream
    for (int n = 0; n < 200; n++) begin
      t = tpls[$urandom_range(0, tpls.size() - 1)];
      ins = build(t);
      run_instr(ins, t, $urandom_range(0, 2), $urandom_range(0, 3), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
